// File: rtl/types_pkg.sv
// Shared widths and the owner tag that follows every SRAM access through
// the read pipeline of the SRAM arbiter.
package types_pkg;

    localparam int SRAM_AW     = 10;
    localparam int SRAM_DW     = 32;
    localparam int TAG_W       = 2;
    localparam int PIPE_CYCLES = 3;

    // Owner of an access: valid marks a real grant, cpu selects the CPU path.
    typedef struct packed {
        logic valid;
        logic cpu;
    } owner_tag_t;

endpackage

// File: rtl/delay.sv
// Fixed-latency delay line: din reappears on dout CYCLES clocks later.
// Synchronous active-low clear empties every stage.
module delay #(
    parameter int SIZE   = 2,
    parameter int CYCLES = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [SIZE-1:0] din,
    output logic [SIZE-1:0] dout
);

    logic [CYCLES-1:0][SIZE-1:0] stage_r;

    // Shift din one stage per clock; reset flushes the whole line.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stage_r <= '0;
        end else begin
            stage_r[0] <= din;
            for (int i = 1; i < CYCLES; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end
    end

    assign dout = stage_r[CYCLES-1];

endmodule

// File: rtl/sram_arb.sv
// Single-port SRAM arbiter between a CPU (one access in flight, level
// request) and a streaming display reader. The display normally wins; a CPU
// that has lost MAX_WAIT times in a row is forced through. Grant in cycle N,
// SRAM address in N+1, SRAM data in N+2, ack/rvalid with data in N+3.
module sram_arb
    import types_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cpu_req,
    input  logic               cpu_we,
    input  logic [SRAM_AW-1:0] cpu_addr,
    input  logic [SRAM_DW-1:0] cpu_wdata,
    output logic               cpu_ack,
    output logic [SRAM_DW-1:0] cpu_rdata,
    input  logic               disp_req,
    input  logic [SRAM_AW-1:0] disp_addr,
    output logic               disp_gnt,
    output logic               disp_rvalid,
    output logic [SRAM_DW-1:0] disp_rdata,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic               sram_we,
    output logic [SRAM_DW-1:0] sram_datao,
    input  logic [SRAM_DW-1:0] sram_datai
);

    localparam logic [2:0] WAIT_LIMIT = 3'(MAX_WAIT);

    logic       cpu_busy_s;
    logic       cpu_elig_s;
    logic       cpu_gnt_s;
    logic       disp_gnt_s;
    logic [1:0] busy_cnt_r;
    logic [2:0] cpu_wait_r;
    logic       rd_cpu_p1_r;
    logic       rd_cpu_p2_r;
    logic       rd_disp_p1_r;
    logic       rd_disp_p2_r;
    owner_tag_t tag_in_s;
    owner_tag_t tag_out_s;

    // Arbitration: one grant per cycle, display first unless the CPU has starved.
    always_comb begin
        cpu_busy_s = (busy_cnt_r != 2'd0);
        cpu_elig_s = cpu_req && !cpu_busy_s;
        cpu_gnt_s  = 1'b0;
        disp_gnt_s = 1'b0;
        if (!rst_n) begin
            cpu_gnt_s  = 1'b0;
            disp_gnt_s = 1'b0;
        end else if (cpu_elig_s && (!disp_req || (cpu_wait_r == WAIT_LIMIT))) begin
            cpu_gnt_s = 1'b1;
        end else if (disp_req) begin
            disp_gnt_s = 1'b1;
        end else begin
            cpu_gnt_s  = 1'b0;
            disp_gnt_s = 1'b0;
        end
    end

    assign disp_gnt       = disp_gnt_s;
    assign tag_in_s.valid = cpu_gnt_s | disp_gnt_s;
    assign tag_in_s.cpu   = cpu_gnt_s;

    // Track the CPU access in flight: loaded on grant, empty again by N+4.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_cnt_r <= 2'd0;
        end else if (cpu_gnt_s) begin
            busy_cnt_r <= 2'd3;
        end else if (busy_cnt_r != 2'd0) begin
            busy_cnt_r <= busy_cnt_r - 2'd1;
        end else begin
            busy_cnt_r <= busy_cnt_r;
        end
    end

    // Count lost arbitration rounds of an eligible CPU, saturating at the limit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cpu_wait_r <= 3'd0;
        end else if (cpu_gnt_s) begin
            cpu_wait_r <= 3'd0;
        end else if (cpu_elig_s && (cpu_wait_r < WAIT_LIMIT)) begin
            cpu_wait_r <= cpu_wait_r + 3'd1;
        end else begin
            cpu_wait_r <= cpu_wait_r;
        end
    end

    // Launch the winner onto the SRAM port; only a CPU write raises sram_we.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sram_addr  <= {SRAM_AW{1'b0}};
            sram_we    <= 1'b0;
            sram_datao <= {SRAM_DW{1'b0}};
        end else if (cpu_gnt_s) begin
            sram_addr  <= cpu_addr;
            sram_we    <= cpu_we;
            sram_datao <= cpu_wdata;
        end else if (disp_gnt_s) begin
            sram_addr  <= disp_addr;
            sram_we    <= 1'b0;
        end else begin
            sram_we    <= 1'b0;
        end
    end

    // Read-steering flags for stages N+1 and N+2 so data lands in the right path.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_cpu_p1_r  <= 1'b0;
            rd_cpu_p2_r  <= 1'b0;
            rd_disp_p1_r <= 1'b0;
            rd_disp_p2_r <= 1'b0;
        end else begin
            rd_cpu_p1_r  <= cpu_gnt_s & ~cpu_we;
            rd_cpu_p2_r  <= rd_cpu_p1_r;
            rd_disp_p1_r <= disp_gnt_s;
            rd_disp_p2_r <= rd_disp_p1_r;
        end
    end

    // Capture returning SRAM data into the owning path; the other path holds.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cpu_rdata  <= {SRAM_DW{1'b0}};
            disp_rdata <= {SRAM_DW{1'b0}};
        end else if (rd_cpu_p2_r) begin
            cpu_rdata  <= sram_datai;
        end else if (rd_disp_p2_r) begin
            disp_rdata <= sram_datai;
        end else begin
            cpu_rdata  <= cpu_rdata;
            disp_rdata <= disp_rdata;
        end
    end

    delay #(
        .SIZE   (TAG_W),
        .CYCLES (PIPE_CYCLES)
    ) u_tag_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (tag_in_s),
        .dout  (tag_out_s)
    );

    assign cpu_ack     = tag_out_s.valid &  tag_out_s.cpu;
    assign disp_rvalid = tag_out_s.valid & ~tag_out_s.cpu;

endmodule

// File: tb/tb_sram_arb.sv
// Scoreboard bench for sram_arb: stimulus queues expected observations,
// a negedge monitor pops and compares them. A second instance runs MAX_WAIT=0.
module tb_sram_arb;

    localparam int K_GNT = 0, K_WE = 1, K_ADDR = 2, K_DATAO = 3, K_ACK = 4,
                   K_RVALID = 5, K_RDATA = 6, K_DRDATA = 7, K_WAIT = 8,
                   K_GNT0 = 9, K_ACK0 = 10;

    typedef struct { int c; int k; logic [31:0] v; } chk_t;
    typedef struct { int c; logic [31:0] v; } dat_t;

    logic        clk, rst_n;
    logic        cpu_req, cpu_we, disp_req, cpu_req0, disp_req0;
    logic [9:0]  cpu_addr, disp_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_ack, disp_gnt, disp_rvalid, sram_we;
    logic [31:0] cpu_rdata, disp_rdata, sram_datao, sram_datai;
    logic [9:0]  sram_addr;
    logic        cpu_ack0, disp_gnt0, disp_rvalid0, sram_we0;
    logic [31:0] cpu_rdata0, disp_rdata0, sram_datao0;
    logic [9:0]  sram_addr0;

    chk_t chk_q[$];
    dat_t cpu_q[$];
    dat_t disp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    bit   done = 1'b0;

    logic [31:0] mem [1024];
    bit          written [1024];

    sram_arb dut (
        .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack),
        .cpu_rdata(cpu_rdata), .disp_req(disp_req), .disp_addr(disp_addr),
        .disp_gnt(disp_gnt), .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata),
        .sram_addr(sram_addr), .sram_we(sram_we), .sram_datao(sram_datao),
        .sram_datai(sram_datai)
    );

    sram_arb #(.MAX_WAIT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req0), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack0),
        .cpu_rdata(cpu_rdata0), .disp_req(disp_req0), .disp_addr(disp_addr),
        .disp_gnt(disp_gnt0), .disp_rvalid(disp_rvalid0), .disp_rdata(disp_rdata0),
        .sram_addr(sram_addr0), .sram_we(sram_we0), .sram_datao(sram_datao0),
        .sram_datai(32'd0)
    );

    // Initial SRAM contents for never-written words.
    function automatic logic [31:0] iv(logic [9:0] a);
        if (a == 10'h2A5) return 32'hDEAD_BEEF;
        return 32'hC0DE_0000 | {22'd0, a};
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // SRAM model: write on sram_we, read data one cycle after the address.
    always @(posedge clk) begin
        if (sram_we === 1'b1) begin
            mem[sram_addr]     <= sram_datao;
            written[sram_addr] <= 1'b1;
        end
        sram_datai <= written[sram_addr] ? mem[sram_addr] : iv(sram_addr);
    end

    function automatic logic [31:0] act_val(int k);
        case (k)
            K_GNT:    return {31'd0, disp_gnt};
            K_WE:     return {31'd0, sram_we};
            K_ADDR:   return {22'd0, sram_addr};
            K_DATAO:  return sram_datao;
            K_ACK:    return {31'd0, cpu_ack};
            K_RVALID: return {31'd0, disp_rvalid};
            K_RDATA:  return cpu_rdata;
            K_DRDATA: return disp_rdata;
            K_WAIT:   return {29'd0, dut.cpu_wait_r};
            K_GNT0:   return {31'd0, disp_gnt0};
            K_ACK0:   return {31'd0, cpu_ack0};
            default:  return 32'hFFFF_FFFF;
        endcase
    endfunction

    function automatic string kname(int k);
        case (k)
            K_GNT:    return "disp_gnt";
            K_WE:     return "sram_we";
            K_ADDR:   return "sram_addr";
            K_DATAO:  return "sram_datao";
            K_ACK:    return "cpu_ack";
            K_RVALID: return "disp_rvalid";
            K_RDATA:  return "cpu_rdata";
            K_DRDATA: return "disp_rdata";
            K_WAIT:   return "cpu_wait";
            K_GNT0:   return "disp_gnt_mw0";
            K_ACK0:   return "cpu_ack_mw0";
            default:  return "unknown";
        endcase
    endfunction

    // Monitor: compare every due expectation and every ack/rvalid event.
    always @(negedge clk) begin
        chk_t e;
        dat_t d;
        if (cyc > 3000) begin
            tests++;
            fails++;
            $display("FAIL timeout at cycle %0d", cyc);
            $display("[TB] %0d tests run, %0d failed", tests, fails);
            $finish;
        end
        while (chk_q.size() > 0 && chk_q[0].c <= cyc) begin
            e = chk_q.pop_front();
            tests++;
            if (e.c < cyc) begin
                fails++;
                $display("FAIL %s stale check for cycle %0d (now %0d)", kname(e.k), e.c, cyc);
            end else if (act_val(e.k) !== e.v) begin
                fails++;
                $display("FAIL %s cycle %0d: got %h, expected %h", kname(e.k), cyc, act_val(e.k), e.v);
            end
        end
        if (cpu_ack === 1'b1) begin
            tests++;
            if (cpu_q.size() == 0) begin
                fails++;
                $display("FAIL cpu_ack unexpected at cycle %0d: got 1, expected 0", cyc);
            end else begin
                d = cpu_q.pop_front();
                if (d.c != cyc || cpu_rdata !== d.v) begin
                    fails++;
                    $display("FAIL cpu_ack_data: got cycle %0d data %h, expected cycle %0d data %h", cyc, cpu_rdata, d.c, d.v);
                end
            end
        end
        while (cpu_q.size() > 0 && cpu_q[0].c < cyc) begin
            d = cpu_q.pop_front();
            tests++;
            fails++;
            $display("FAIL cpu_ack missing: got none, expected at cycle %0d data %h", d.c, d.v);
        end
        if (disp_rvalid === 1'b1) begin
            tests++;
            if (disp_q.size() == 0) begin
                fails++;
                $display("FAIL disp_rvalid unexpected at cycle %0d: got 1, expected 0", cyc);
            end else begin
                d = disp_q.pop_front();
                if (d.c != cyc || disp_rdata !== d.v) begin
                    fails++;
                    $display("FAIL disp_rdata: got cycle %0d data %h, expected cycle %0d data %h", cyc, disp_rdata, d.c, d.v);
                end
            end
        end
        while (disp_q.size() > 0 && disp_q[0].c < cyc) begin
            d = disp_q.pop_front();
            tests++;
            fails++;
            $display("FAIL disp_rvalid missing: got none, expected at cycle %0d data %h", d.c, d.v);
        end
        if (done) begin
            tests++;
            if (chk_q.size() + cpu_q.size() + disp_q.size() != 0) begin
                fails++;
                $display("FAIL leftover expectations: got %0d pending, expected 0",
                         chk_q.size() + cpu_q.size() + disp_q.size());
            end
            $display("[TB] %0d tests run, %0d failed", tests, fails);
            $finish;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp(int c, int k, logic [31:0] v);
        chk_t e;
        e.c = c; e.k = k; e.v = v;
        chk_q.push_back(e);
    endtask

    task automatic exp_cpu(int c, logic [31:0] v);
        dat_t d;
        d.c = c; d.v = v;
        cpu_q.push_back(d);
    endtask

    task automatic exp_disp(int c, logic [31:0] v);
        dat_t d;
        d.c = c; d.v = v;
        disp_q.push_back(d);
    endtask

    task automatic cpu_set(logic req, logic we, logic [9:0] a, logic [31:0] wd);
        cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
    endtask

    // Directed stimulus.
    initial begin
        int t;
        rst_n = 1'b0; disp_req = 1'b1; disp_addr = 10'd0;
        cpu_req0 = 1'b0; disp_req0 = 1'b0;
        cpu_set(1'b0, 1'b0, 10'd0, 32'd0);
        tick(); tick();
        // Reset state, with disp_req high while in reset
        t = cyc;
        exp(t, K_GNT, 32'd0);   exp(t, K_WE, 32'd0);     exp(t, K_ADDR, 32'd0);
        exp(t, K_DATAO, 32'd0); exp(t, K_ACK, 32'd0);    exp(t, K_RVALID, 32'd0);
        exp(t, K_RDATA, 32'd0); exp(t, K_DRDATA, 32'd0); exp(t, K_WAIT, 32'd0);
        tick();
        disp_req = 1'b0; rst_n = 1'b1;
        tick();

        // CPU read alone, no re-grant during the ack cycle
        t = cyc;
        exp(t + 1, K_ADDR, 32'h2A5); exp(t + 1, K_WE, 32'd0);
        exp(t + 4, K_ADDR, 32'h2A5); exp(t + 4, K_WE, 32'd0); exp(t + 4, K_ACK, 32'd0);
        exp_cpu(t + 3, 32'hDEAD_BEEF);
        cpu_set(1'b1, 1'b0, 10'h2A5, 32'd0);
        repeat (4) tick();
        cpu_req = 1'b0;
        repeat (4) tick();

        // CPU write to the top address, then read it back
        t = cyc;
        exp(t + 1, K_WE, 32'd1); exp(t + 1, K_ADDR, 32'h3FF); exp(t + 1, K_DATAO, 32'h1234_5678);
        exp(t + 2, K_WE, 32'd0);
        exp_cpu(t + 3, 32'hDEAD_BEEF);
        cpu_set(1'b1, 1'b1, 10'h3FF, 32'h1234_5678);
        repeat (4) tick();
        cpu_req = 1'b0;
        tick();
        t = cyc;
        exp(t + 1, K_ADDR, 32'h3FF); exp(t + 1, K_WE, 32'd0);
        exp_cpu(t + 3, 32'h1234_5678);
        cpu_set(1'b1, 1'b0, 10'h3FF, 32'h1234_5678);
        repeat (4) tick();
        cpu_req = 1'b0;
        repeat (2) tick();

        // Display stream of 8 reads
        t = cyc;
        for (int c = 0; c <= 8; c++) begin
            exp(t + c, K_GNT, (c < 8) ? 32'd1 : 32'd0);
            if (c >= 1) exp(t + c, K_ADDR, 32'(c - 1));
        end
        for (int i = 0; i < 8; i++) exp_disp(t + 3 + i, iv(10'(i)));
        for (int i = 0; i < 8; i++) begin
            disp_req = 1'b1; disp_addr = 10'(i);
            tick();
        end
        disp_req = 1'b0;
        repeat (4) tick();

        // Starvation limit: display loses only in cycle 4
        t = cyc;
        for (int i = 0; i < 12; i++) begin
            exp(t + i, K_GNT, (i == 4) ? 32'd0 : 32'd1);
            if (i == 4) exp(t + i, K_WAIT, 32'd4);
            if (i == 5) begin
                exp(t + i, K_WAIT, 32'd0);
                exp(t + i, K_ADDR, 32'h2A5);
            end
        end
        for (int i = 0; i < 12; i++) if (i != 4) exp_disp(t + 3 + i, iv(10'(16 + i)));
        exp_cpu(t + 7, 32'hDEAD_BEEF);
        for (int i = 0; i < 12; i++) begin
            disp_req = 1'b1; disp_addr = 10'(16 + i);
            cpu_set(i < 8, 1'b0, 10'h2A5, 32'd0);
            tick();
        end
        disp_req = 1'b0;
        repeat (4) tick();

        // Reset mid-flight: display read in flight, CPU write in the reset cycle
        disp_req = 1'b1; disp_addr = 10'd3;
        tick();
        t = cyc;
        disp_req = 1'b0;
        cpu_set(1'b1, 1'b1, 10'h055, 32'hBAD0_BAD0);
        rst_n = 1'b0;
        exp(t + 1, K_WE, 32'd0);    exp(t + 1, K_ADDR, 32'd0); exp(t + 1, K_DATAO, 32'd0);
        exp(t + 1, K_WAIT, 32'd0);  exp(t + 1, K_RDATA, 32'd0); exp(t + 1, K_DRDATA, 32'd0);
        exp(t + 2, K_RVALID, 32'd0);
        exp(t + 3, K_ACK, 32'd0);   exp(t + 4, K_ACK, 32'd0);  exp(t + 4, K_WAIT, 32'd0);
        tick();
        rst_n = 1'b1; cpu_req = 1'b0;
        repeat (5) tick();
        t = cyc;
        exp_cpu(t + 3, iv(10'h055));
        cpu_set(1'b1, 1'b0, 10'h055, 32'd0);
        repeat (4) tick();
        cpu_req = 1'b0;
        repeat (2) tick();

        // MAX_WAIT=0 instance: CPU wins whenever eligible
        t = cyc;
        for (int i = 0; i < 12; i++) begin
            exp(t + i, K_GNT0, (i % 4 != 0) ? 32'd1 : 32'd0);
            exp(t + i, K_ACK0, (i % 4 == 3) ? 32'd1 : 32'd0);
        end
        for (int i = 0; i < 12; i++) begin
            cpu_req0 = 1'b1; disp_req0 = 1'b1; disp_addr = 10'(i);
            cpu_we = 1'b0; cpu_addr = 10'h2A5;
            tick();
        end
        cpu_req0 = 1'b0; disp_req0 = 1'b0;
        repeat (6) tick();
        done = 1'b1;
    end

endmodule

// File: doc/sram_arb.md
SRAM_ARB -- requirements
Module: sram_arb

Interface
REQ-001 Parameter MAX_WAIT, default 4: lost arbitration cycles the CPU tolerates before it is forced to win; 0 gives the CPU absolute priority.
REQ-002 clk  input  1  single clock; all logic is synchronous to its rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 cpu_req  input  1  CPU access request, level; held until cpu_ack.
REQ-005 cpu_we  input  1  1 = write, 0 = read; stable while cpu_req is high.
REQ-006 cpu_addr  input  10  CPU word address; stable while cpu_req is high.
REQ-007 cpu_wdata  input  32  CPU write data; stable while cpu_req is high.
REQ-008 cpu_ack  output  1  one-cycle completion pulse, for reads and writes.
REQ-009 cpu_rdata  output  32  CPU read data, valid with cpu_ack on reads.
REQ-010 disp_req  input  1  display read request; one read per cycle, streaming.
REQ-011 disp_addr  input  10  display word address.
REQ-012 disp_gnt  output  1  combinational; disp_req accepted this cycle.
REQ-013 disp_rvalid  output  1  display read data valid strobe.
REQ-014 disp_rdata  output  32  display read data.
REQ-015 sram_addr  output  10  SRAM address, registered.
REQ-016 sram_we  output  1  SRAM write enable, registered.
REQ-017 sram_datao  output  32  SRAM write data, registered.
REQ-018 sram_datai  input  32  SRAM read data, valid one cycle after sram_addr.

Function
REQ-019 Exactly one access is granted per cycle N, with the arbitration decision made combinationally from that cycle's requests.
REQ-020 The CPU is eligible in cycle N only if cpu_req=1 and it has no access in flight; an access is in flight from its grant cycle through its cpu_ack cycle inclusive.
REQ-021 Priority: the display wins unless the CPU is eligible and cpu_wait==MAX_WAIT, in which case the CPU wins and disp_gnt=0.
REQ-022 If only one side requests (CPU counted only when eligible), that side wins.
REQ-023 cpu_wait, 3 bits, increments and saturates at MAX_WAIT in each cycle the CPU is eligible and loses.
REQ-024 cpu_wait clears on a CPU grant and holds otherwise.
REQ-025 Winner's address/we/wdata appear on sram_addr/sram_we/sram_datao in cycle N+1.
REQ-026 sram_we=1 only in cycle N+1 of a CPU write grant; display grants always drive sram_we=0.
REQ-027 With no grant, sram_we=0 and sram_addr/sram_datao hold their previous values.
REQ-028 sram_datai is captured at the end of N+2.
REQ-029 disp_rvalid=1 with disp_rdata in cycle N+3 for every disp_gnt in cycle N; the display path is fully pipelined at 1 read/cycle.
REQ-030 cpu_ack=1 for exactly cycle N+3 of a CPU grant.
REQ-031 On a CPU read, cpu_rdata takes the SRAM data in cycle N+3; on a CPU write, cpu_rdata holds its previous value.
REQ-032 The CPU is eligible again in N+4 at the earliest, so a cpu_req still high during the cpu_ack cycle is not re-granted.
REQ-033 A 2-bit owner tag (valid, cpu) travels with each grant through stages N+1..N+3 to steer returned data; the CPU and display paths never exchange data.
REQ-034 Address wrap: addresses 0x000 and 0x3FF are ordinary values; there is no address arithmetic.

Reset
REQ-035 When rst_n=0 at a clock edge, the following are cleared to 0 in the next cycle: cpu_ack, disp_rvalid, sram_we, sram_addr, sram_datao, cpu_rdata, disp_rdata, cpu_wait and all pipeline tags.
REQ-036 Reset mid-operation drops all in-flight accesses with no ack or rvalid ever issued.
REQ-037 A CPU write granted in the same cycle that rst_n is sampled low is not written.
REQ-038 disp_gnt=0 in any cycle while rst_n=0.

Structure
REQ-039 Constants SRAM_AW=10 and SRAM_DW=32 shall be defined in types_pkg and used for all address and data widths.
REQ-040 The owner-tag pipeline shall use the existing delay sub-module (SIZE=2, CYCLES=3); all other logic shall be local to sram_arb.

Verification
REQ-041 CPU read alone: SRAM preloaded 0x2A5=0xDEADBEEF; cpu_req read 0x2A5 at cycle 0 -> sram_addr=0x2A5 in cycle 1, cpu_ack and cpu_rdata=0xDEADBEEF in cycle 3, no second grant in cycle 3.
REQ-042 CPU write then read: write 0x3FF=0x12345678 -> sram_we=1 only in cycle 1, cpu_ack in cycle 3; a subsequent read of 0x3FF returns 0x12345678.
REQ-043 Display stream: disp_req held 8 cycles with addresses 0..7 -> disp_gnt=1 in all 8 cycles; disp_rvalid in cycles 3..10 with data for addresses 0..7 in order.
REQ-044 Starvation, MAX_WAIT=4: disp_req continuous and cpu_req read raised at cycle 0 -> disp_gnt=0 only in cycle 4; CPU granted in cycle 4, cpu_ack in cycle 7, display data order intact.
REQ-045 Reset mid-flight: CPU write granted at cycle 0, rst_n=0 sampled at the end of cycle 0 -> sram_we=0 in cycle 1, no cpu_ack, cpu_wait=0 afterwards.
REQ-046 MAX_WAIT=0 with both sides requesting every cycle -> the CPU wins whenever eligible (cycles 0, 4, 8, ...) and the display wins all other cycles.
